// File: rtl/inst_refill_pkg.sv
// rtl/inst_refill_pkg.sv - shared types and constants for the instruction refill engine
package inst_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } refill_state_t;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;

    localparam logic [31:0] NOP_INST = 32'h0800_0000;

    // Byte offset of word idx within a line.
    function automatic logic [OFFSET_W-1:0] word_off(input logic [1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/inst_refill_if.sv
// rtl/inst_refill_if.sv - cache-side and memory-side signals of the refill engine
interface inst_refill_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              miss;
    logic [ADDR_W-1:0] miss_addr;
    logic              busy;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_valid;
    logic [127:0]      line_data;
    logic [ADDR_W-1:0] line_addr;
    logic              line_valid;
    logic [CNT_W-1:0]  refill_count;

    modport master (
        input  miss, miss_addr, mem_rdata, mem_valid,
        output busy, mem_rd, mem_addr, line_data, line_addr, line_valid, refill_count
    );

    modport slave (
        output miss, miss_addr, mem_rdata, mem_valid,
        input  busy, mem_rd, mem_addr, line_data, line_addr, line_valid, refill_count
    );
endinterface

// File: rtl/refill_line_buf.sv
// rtl/refill_line_buf.sv - 4x32 line assembly buffer, written by word index
module refill_line_buf
    import inst_refill_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [1:0]               wr_idx,
    input  logic [31:0]              wr_data,
    output logic [LINE_WORDS*32-1:0] line
);
    logic [31:0] words [LINE_WORDS];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) line[32*i +: 32] = words[i];
    end
endmodule

// File: rtl/inst_refill_engine.sv
// rtl/inst_refill_engine.sv - fetches a 16-byte instruction line word by word on a cache miss
module inst_refill_engine
    import inst_refill_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    inst_refill_if.master bus
);
    refill_state_t             state;
    logic [ADDR_W-1:0]         base;
    logic [1:0]                cnt;
    logic                      xfer;
    logic                      accept;
    logic [LINE_WORDS*32-1:0]  buf_line;
    logic [LINE_WORDS*32-1:0]  next_line;

    assign xfer   = (state == FETCH) && bus.mem_rd && bus.mem_valid;
    assign accept = (state == IDLE) && bus.miss;

    refill_line_buf u_buf (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (accept),
        .wr_en   (xfer),
        .wr_idx  (cnt),
        .wr_data (bus.mem_rdata),
        .line    (buf_line)
    );

    // The last word lands in the buffer on the same edge the line is published,
    // so it is merged in from mem_rdata directly.
    always_comb begin
        next_line = buf_line;
        next_line[32*cnt +: 32] = bus.mem_rdata;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            base             <= '0;
            cnt              <= '0;
            bus.busy         <= 1'b0;
            bus.mem_rd       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.line_data    <= '0;
            bus.line_addr    <= '0;
            bus.line_valid   <= 1'b0;
            bus.refill_count <= '0;
        end else begin
            bus.line_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss) begin
                        base         <= {bus.miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        bus.mem_addr <= {bus.miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        cnt          <= '0;
                        bus.mem_rd   <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (xfer) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            bus.mem_rd       <= 1'b0;
                            bus.line_valid   <= 1'b1;
                            bus.line_data    <= next_line;
                            bus.line_addr    <= base;
                            bus.refill_count <= bus.refill_count + 1'b1;
                            state            <= DONE;
                        end else begin
                            bus.mem_addr <= {base[ADDR_W-1:OFFSET_W], word_off(cnt + 2'd1)};
                        end
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_refill_engine.sv
// tb/tb_inst_refill_engine.sv - directed scoreboard bench for inst_refill_engine
module tb_inst_refill_engine;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    inst_refill_if #(.ADDR_W(32), .CNT_W(2)) bus ();

    inst_refill_engine #(.ADDR_W(32), .CNT_W(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } line_t;
    line_t sb[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input logic [31:0] base);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = (base + 32'(4*k)) ^ 32'hA5A5_0000;
        return r;
    endfunction

    always @(negedge Clk) begin
        if (bus.line_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious line_valid", {127'd0, bus.line_valid}, 128'd0);
            end else begin
                line_t e;
                e = sb.pop_front();
                chk("line_addr", {96'd0, bus.line_addr}, {96'd0, e.addr});
                chk("line_data", bus.line_data, e.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, " busy"},         {127'd0, bus.busy}, 128'd0);
        chk({tag, " mem_rd"},       {127'd0, bus.mem_rd}, 128'd0);
        chk({tag, " mem_addr"},     {96'd0, bus.mem_addr}, 128'd0);
        chk({tag, " line_data"},    bus.line_data, 128'd0);
        chk({tag, " line_addr"},    {96'd0, bus.line_addr}, 128'd0);
        chk({tag, " line_valid"},   {127'd0, bus.line_valid}, 128'd0);
        chk({tag, " refill_count"}, {126'd0, bus.refill_count}, 128'd0);
    endtask

    // Drives one miss, stalls nwait cycles on word wait_word, optionally raises a
    // second miss at 0x200 in FETCH cycle dup_cycle, and checks timing and count.
    task automatic refill(input logic [31:0] a, input int wait_word, input int nwait,
                          input int dup_cycle, input logic [1:0] exp_cnt);
        logic [31:0] base;
        int cycles, word, wcnt;
        base = {a[31:4], 4'h0};
        word = 0;
        wcnt = 0;
        sb.push_back('{base, exp_line(base)});
        bus.miss = 1'b1;
        bus.miss_addr = a;
        bus.mem_valid = 1'b1;
        @(negedge Clk);
        cycles = 1;
        while (bus.line_valid !== 1'b1 && cycles < 40) begin
            bus.miss      = (cycles == dup_cycle);
            bus.miss_addr = (cycles == dup_cycle) ? 32'h200 : a;
            chk("busy in FETCH", {127'd0, bus.busy}, 128'd1);
            chk("mem_rd in FETCH", {127'd0, bus.mem_rd}, 128'd1);
            chk("mem_addr", {96'd0, bus.mem_addr}, {96'd0, base + 32'(4*word)});
            if (word == wait_word && wcnt < nwait) begin
                bus.mem_valid = 1'b0;
                wcnt++;
            end else begin
                bus.mem_valid = 1'b1;
                word++;
            end
            @(negedge Clk);
            cycles++;
        end
        bus.miss = 1'b0;
        chk("latency", 128'(cycles), 128'(5 + nwait));
        chk("busy in DONE", {127'd0, bus.busy}, 128'd1);
        chk("mem_rd in DONE", {127'd0, bus.mem_rd}, 128'd0);
        @(negedge Clk);
        chk("line_valid width", {127'd0, bus.line_valid}, 128'd0);
        chk("busy after DONE", {127'd0, bus.busy}, 128'd0);
        chk("refill_count", {126'd0, bus.refill_count}, {126'd0, exp_cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs [5];
        logic [1:0]  cnts  [5];
        addrs = '{32'h0000_1234, 32'h0000_0FF0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h8000_0040};
        cnts  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        bus.miss = 1'b0;
        bus.miss_addr = '0;
        bus.mem_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle busy", {127'd0, bus.busy}, 128'd0);

        // zero-wait refill
        refill(32'h0000_0048, 0, 0, 0, 2'd1);
        // two wait states on word 1
        refill(32'h0000_0048, 1, 2, 0, 2'd2);
        // miss while busy is dropped; re-issued miss back-to-back succeeds
        refill(32'h0000_0048, 0, 0, 2, 2'd3);
        refill(32'h0000_0200, 0, 0, 0, 2'd0);

        // reset after word 2 transfers
        bus.miss = 1'b1;
        bus.miss_addr = 32'h0000_0048;
        bus.mem_valid = 1'b1;
        @(negedge Clk);
        bus.miss = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        chk("pre-reset mem_addr", {96'd0, bus.mem_addr}, 128'h4C);
        Reset = 1'b1;
        #1;
        check_all_zero("mid-refill reset");
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge Clk);
        chk("idle after reset", {127'd0, bus.busy}, 128'd0);
        refill(32'h0000_0080, 0, 0, 0, 2'd1);

        // counter wrap with a 2-bit counter
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 5; i++) refill(addrs[i], i % 4, i % 3, 0, cnts[i]);

        repeat (3) @(negedge Clk);
        chk("scoreboard drained", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_refill_engine.md
# inst_refill_engine

Memory-side refill engine for the instruction cache. When the cache reports a miss, this block fetches the four 32-bit words of the aligned 16-byte line from word-wide instruction memory. It then delivers them as one 128-bit line with a one-cycle valid pulse, so the cache can install the line at index addr[6:4] with tag addr[31:7]. It sits between the instruction cache and the instruction memory model.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- CNT_W, 16, width of the refill statistics counter

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- miss  in  1  cache miss request, sampled on rising edge of Clk
- miss_addr  in  ADDR_W  faulting byte address
- busy  out  1  refill in progress (state != IDLE)
- mem_rd  out  1  memory read request, held until accepted
- mem_addr  out  ADDR_W  word address of the current request
- mem_rdata  in  32  memory read data
- mem_valid  in  1  mem_rdata valid; accepts the current request
- line_data  out  128  assembled line; word k at [32k+31:32k]
- line_addr  out  ADDR_W  line base address, low 4 bits zero
- line_valid  out  1  one-cycle pulse, line ready for the cache
- refill_count  out  CNT_W  completed refills; wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, DONE.
- IDLE:
  - On miss=1, latch base = {miss_addr[ADDR_W-1:4], 4'b0}, clear word counter cnt (2 bits), go to FETCH.
  - miss_addr[3:0] is ignored; no critical-word-first ordering.
- FETCH:
  - Drive mem_rd=1 and mem_addr = base + 4*cnt.
  - A cycle with mem_rd=1 and mem_valid=1 is a transfer: write mem_rdata into line word cnt, then cnt++.
  - On a transfer with cnt==3, go to DONE. Otherwise stay in FETCH; the next word's request starts the following cycle.
  - mem_valid=0 stalls indefinitely, with mem_addr held stable.
- DONE:
  - line_valid=1 for exactly one cycle, with line_addr=base.
  - refill_count increments; 2^CNT_W-1 wraps to 0.
  - Return to IDLE.
- line_data and line_addr hold their last completed values until the next DONE. Partially filled words never appear on line_data: assembly uses an internal buffer, copied to the outputs on entry to DONE.
- miss while busy=1 is ignored and not queued. The cache re-asserts it after installing the line.
- mem_valid outside FETCH is ignored.
- Reset (asserted at any time, including mid-FETCH):
  - State returns to IDLE and the refill is aborted; no line_valid is produced.
  - All outputs go to 0: busy, mem_rd, mem_addr, line_data, line_addr, line_valid, refill_count.

## Timing
- Zero-wait memory (mem_valid tied 1): miss sampled at edge 0; FETCH during cycles 1–4 (words 0–3); line_valid high in cycle 5; idle in cycle 6. Minimum latency from miss to line_valid is 5 cycles.
- Each memory wait cycle adds exactly one cycle of latency.
- busy rises the cycle after miss is sampled and falls the cycle after line_valid.
- A new miss presented in the cycle after line_valid is accepted, giving back-to-back refills every 6 cycles.
- mem_rd and mem_addr are registered outputs; they change only on Clk edges or on Reset.

## Structure
- Shared package inst_refill_pkg holds:
  - state enum {IDLE, FETCH, DONE}
  - LINE_WORDS=4, LINE_BYTES=16, OFFSET_W=4
  - NOP_INST=32'h0800_0000 (the cache's miss filler)
- One sub-module, refill_line_buf: a 4×32 write-by-index buffer with a clear input. It is instantiated once.
- The FSM, counters and output registers stay in the top module.

## Test plan
- Zero-wait refill: miss_addr=0x0000_0048, memory word(a)=a^0xA5A5_0000.
  - mem_addr sequence is 0x40, 0x44, 0x48, 0x4C.
  - line_valid pulses in cycle 5, with line_addr=0x40 and line_data={0xA5A5_004C, 0xA5A5_0048, 0xA5A5_0044, 0xA5A5_0040}.
  - refill_count=1.
- Wait states: two wait cycles on word 1 only.
  - mem_addr holds 0x44 for 3 cycles.
  - line_valid arrives in cycle 7.
  - Data is identical to the zero-wait case.
- Miss while busy: a second miss with miss_addr=0x200 is asserted during FETCH.
  - Only one line_valid is produced, with line_addr=0x40; no fetch of 0x200 occurs.
  - A miss at 0x200 re-issued after line_valid then refills line_addr=0x200.
- Reset mid-refill: assert Reset after word 2 transfers.
  - All outputs are 0 immediately and no line_valid is produced.
  - A subsequent miss at 0x80 completes normally with refill_count=1.
- Counter wrap: with CNT_W=2, run 5 refills; refill_count reads 1,2,3,0,1.
